// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with press/release debounce
//   clk       system clock
//   rst       synchronous active-high reset
//   row       keypad rows, active-low, asynchronous
//   col       column drive, active-low, one bit low
//   key_code  last accepted key, 4*row_index + col_index
//   key_valid one-cycle strobe on acceptance
//   key_held  high from acceptance until release debounce completes
module keypad_scan #(
  parameter int SCAN_CNT_MAX = 12_500,
  parameter int DB_CNT_MAX   = 625_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int CW = $clog2((SCAN_CNT_MAX > DB_CNT_MAX ? SCAN_CNT_MAX : DB_CNT_MAX) + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CNT_MAX - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CNT_MAX - 1);
  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    col_idx;
  logic [3:0]    row_m, row_s, row_lat, low;
  logic [1:0]    row_idx;
  logic          single;
  assign col = ~(4'b0001 << col_idx);
  // exactly one low row; ghosted multi-key patterns are rejected
  assign low    = ~row_s;
  assign single = (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
  always_comb
    row_idx = !row_lat[0] ? 2'd0 : !row_lat[1] ? 2'd1 : !row_lat[2] ? 2'd2 : 2'd3;
  always_ff @(posedge clk) begin
    if (rst) begin
      row_m     <= 4'hF;
      row_s     <= 4'hF;
      state     <= SCAN;
      cnt       <= '0;
      col_idx   <= 2'd0;
      row_lat   <= 4'hF;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      row_m     <= row;
      row_s     <= row_m;
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (single) begin
              row_lat <= row_s;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_s != row_lat) begin
            cnt   <= '0;
            state <= SCAN;
          end else if (cnt == DB_LAST) begin
            cnt       <= '0;
            key_code  <= {row_idx, col_idx};
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          // any low row restarts the release window
          if (row_s != 4'hF) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            cnt      <= '0;
            key_held <= 1'b0;
            col_idx  <= col_idx + 2'd1;
            state    <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= SCAN;
        end
      endcase
    end
  end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanner for the 4×4 matrix keypad used for passcode digit entry. It is the input-side counterpart of the multiplexed 7-segment display scan.
- Drives one active-low column at a time and samples the active-low rows.
- Debounces press and release.
- Emits a single-cycle `key_valid` strobe with a 4-bit `key_code`.

It sits between the board pins and `numeric_code_detonator`, and supplies the digit bus and digit strobe in place of the raw `A`/`confirm` switches.

## Interface
- `SCAN_CNT_MAX`, default 12_500: column dwell in clocks (100 µs at 125 MHz) before rows are sampled; must be ≥ 3.
- `DB_CNT_MAX`, default 625_000: debounce window in clocks (5 ms), applied to both press and release; must be ≥ 2.
- `clk`  in  1  system clock, 125 MHz
- `rst`  in  1  reset, synchronous and active-high
- `row`  in  4  keypad rows, active-low, pulled up externally, asynchronous to `clk`
- `col`  out  4  keypad column drive, active-low, exactly one bit low at all times
- `key_code`  out  4  code of last accepted key, equal to 4·row_index + col_index
- `key_valid`  out  1  one-cycle strobe; `key_code` is valid on this cycle
- `key_held`  out  1  high from acceptance until release debounce completes

## Operation
- `row` passes through a 2-flop synchronizer, giving `row_s`. All decisions use `row_s`.
- `col_idx` (2 bit) selects the driven column: `col = ~(4'b0001 << col_idx)`.
- One counter `cnt`, wide enough for max(`SCAN_CNT_MAX`, `DB_CNT_MAX`). It is cleared on every state change.
- A row pattern is "single" when exactly one bit of `row_s` is 0. Zero or ≥2 low bits count as no key; ghosted multi-key presses are rejected.

FSM states:
- **SCAN**
  - Increment `cnt` each cycle.
  - When `cnt == SCAN_CNT_MAX-1`, sample `row_s`.
  - If the pattern is single: latch it into `row_lat`, go to DEBOUNCE, keep `col_idx`.
  - Otherwise: `col_idx <= col_idx+1` (wraps 3→0) and stay in SCAN.
- **DEBOUNCE**
  - If `row_s != row_lat` on any cycle: go to SCAN with the same `col_idx`.
  - When `cnt == DB_CNT_MAX-1` with a match: register `key_code <= {row_idx, col_idx}`, `key_valid <= 1`, `key_held <= 1`, and go to HOLD.
- **HOLD**
  - Keep `col_idx`.
  - `cnt` increments while `row_s == 4'hF` and clears on any other value.
  - When `cnt == DB_CNT_MAX-1` with `row_s == 4'hF`: `key_held <= 0`, `col_idx <= col_idx+1`, go to SCAN.
- Held keys do not auto-repeat: exactly one `key_valid` is produced per press.
- `key_code` keeps its value until the next accepted key.

## Timing
- Reset values:
  - `col = 4'b1110`, `col_idx = 0`
  - `key_code = 4'h0`, `key_valid = 0`, `key_held = 0`
  - state SCAN, `cnt = 0`, synchronizer flops `4'hF`
- Reset asserted mid-operation, in any state, returns everything to the reset values on the next edge. No strobe is emitted.
- Input latency: a `row` change reaches `row_s` 2 clocks later.
- Column period when idle: `SCAN_CNT_MAX` clocks per column, so a full sweep takes 4·`SCAN_CNT_MAX`.
- Press latency:
  - The SCAN sample cycle is S. DEBOUNCE occupies cycles S+1 … S+`DB_CNT_MAX`.
  - `key_valid` is high for exactly cycle S+`DB_CNT_MAX`+1. `key_held` rises on the same cycle.
- Release latency:
  - The first all-high `row_s` cycle is R. `key_held` falls on cycle R+`DB_CNT_MAX`.
  - SCAN resumes on the next column from that cycle.
- `key_valid` and `key_held` rise together. `key_valid` never asserts while already in HOLD.
- A bounce of any length shorter than `DB_CNT_MAX` during DEBOUNCE aborts acceptance. During HOLD it restarts the release window.
- Simultaneous second key in another row during HOLD: ignored. The release window cannot complete until all rows are high.

## Test plan
All scenarios use `SCAN_CNT_MAX=4`, `DB_CNT_MAX=8`.
- Reset, then no key for 32 cycles → `col` steps 1110→1101→1011→0111→1110, dwelling 4 cycles per column; `key_valid` stays 0.
- Model holds row 2 low whenever col 1 is driven, held for 20 cycles → exactly one `key_valid` pulse, 9 cycles after the sample cycle, with `key_code=4'h9` and `key_held=1`. The column stays at 1101 until release.
- Press as above but release the row for 1 cycle at DEBOUNCE cycle 5 → no `key_valid`; the scanner returns to SCAN on col 1. The press restored afterwards is accepted with a new 8-cycle window.
- Press rows 0 and 3 together on col 2 → no `key_valid`; scanning continues normally.
- After acceptance of key 4'h9: release with 1 re-press glitch at release cycle 4, then stay high → `key_held` falls 8 cycles after the last glitch, and `col` advances to 1011.
- Assert `rst` during DEBOUNCE and during HOLD → the next cycle shows `col=1110`, `key_held=0`, `key_valid=0`, `key_code=0`.
